// File: rtl/coin_ctrl_pkg.sv
// coin_ctrl_pkg
//   Shared types and constants for the change dispense sequencer.
//   - state_t       : sequencer states (IDLE, LOAD, PICK, CMD, GAP, DONE)
//   - cmd_t         : coin command chosen by coin_pick
//   - VAL_*         : coin values in nickel units
//   - cmd_onehot()  : maps a cmd_t to the {two_dime, dime, nickel} strobe triple
package coin_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PICK = 3'd2,
    ST_CMD  = 3'd3,
    ST_GAP  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE     = 2'd0,
    CMD_NICKEL   = 2'd1,
    CMD_DIME     = 2'd2,
    CMD_TWO_DIME = 2'd3
  } cmd_t;

  localparam int unsigned VAL_NICKEL    = 32'd1;
  localparam int unsigned VAL_DIME      = 32'd2;
  localparam int unsigned VAL_TWO_DIME  = 32'd4;
  // Dimes consumed by one two_dime command.
  localparam int unsigned DIMES_PER_TWO = 32'd2;

  // Strobe pattern {two_dime_out, dime_out, nickel_out} for a command.
  function automatic logic [2:0] cmd_onehot(input cmd_t c);
    logic [2:0] bits;
    case (c)
      CMD_NICKEL:   bits = 3'b001;
      CMD_DIME:     bits = 3'b010;
      CMD_TWO_DIME: bits = 3'b100;
      default:      bits = 3'b000;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/change_dispense_ctrl_coin_pick.sv
// coin_pick
//   Purely combinational greedy coin selection. Every decrement is guarded by
//   its own availability test, so the next-state counts can never wrap.
//   Ports:
//     remaining       in   AMT_W  nickel units still owed
//     nickel_cnt      in   CNT_W  nickels on hand
//     dime_cnt        in   CNT_W  dimes on hand
//     cmd             out  cmd_t  chosen command (CMD_NONE = nothing dispensable)
//     remaining_nxt   out  AMT_W  remaining after the command
//     nickel_cnt_nxt  out  CNT_W  nickels after the command
//     dime_cnt_nxt    out  CNT_W  dimes after the command
module coin_pick
  import coin_ctrl_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int AMT_W = 8
) (
  input  logic [AMT_W-1:0] remaining,
  input  logic [CNT_W-1:0] nickel_cnt,
  input  logic [CNT_W-1:0] dime_cnt,
  output cmd_t             cmd,
  output logic [AMT_W-1:0] remaining_nxt,
  output logic [CNT_W-1:0] nickel_cnt_nxt,
  output logic [CNT_W-1:0] dime_cnt_nxt
);

  // Largest coin first; first matching rule wins.
  always_comb begin
    cmd            = CMD_NONE;
    remaining_nxt  = remaining;
    nickel_cnt_nxt = nickel_cnt;
    dime_cnt_nxt   = dime_cnt;
    if ((remaining >= AMT_W'(VAL_TWO_DIME)) && (dime_cnt >= CNT_W'(DIMES_PER_TWO))) begin
      cmd           = CMD_TWO_DIME;
      remaining_nxt = remaining - AMT_W'(VAL_TWO_DIME);
      dime_cnt_nxt  = dime_cnt - CNT_W'(DIMES_PER_TWO);
    end else if ((remaining >= AMT_W'(VAL_DIME)) && (dime_cnt >= CNT_W'(1'b1))) begin
      cmd           = CMD_DIME;
      remaining_nxt = remaining - AMT_W'(VAL_DIME);
      dime_cnt_nxt  = dime_cnt - CNT_W'(1'b1);
    end else if ((remaining >= AMT_W'(VAL_NICKEL)) && (nickel_cnt >= CNT_W'(1'b1))) begin
      cmd            = CMD_NICKEL;
      remaining_nxt  = remaining - AMT_W'(VAL_NICKEL);
      nickel_cnt_nxt = nickel_cnt - CNT_W'(1'b1);
    end else begin
      cmd = CMD_NONE;
    end
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl
//   Sequencer in front of the coin_counter datapath. Accepts inventory loads
//   and change requests, breaks requests into single registered coin command
//   pulses separated by an idle cycle, keeps a mirror of the inventory and
//   reports completion or an exact-change shortfall.
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     load_req/load_nickels/load_dimes inventory load request (sampled in IDLE)
//     req_valid/req_amount/req_ready  change request handshake (nickel units)
//     done_valid/done_short/done_remain completion pulse and result
//     load/nickels/dimes              datapath load strobe and values
//     nickel_out/dime_out/two_dime_out datapath dispense strobes
//     empty                           datapath inventory-empty flag
//     nickel_cnt/dime_cnt             mirrored inventory
//     busy                            sequencer not in IDLE
//     sync_err                        sticky mirror/datapath mismatch
module change_dispense_ctrl
  import coin_ctrl_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_req,
  input  logic [CNT_W-1:0] load_nickels,
  input  logic [CNT_W-1:0] load_dimes,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             done_valid,
  output logic             done_short,
  output logic [AMT_W-1:0] done_remain,
  output logic             load,
  output logic [CNT_W-1:0] nickels,
  output logic [CNT_W-1:0] dimes,
  output logic             nickel_out,
  output logic             dime_out,
  output logic             two_dime_out,
  input  logic             empty,
  output logic [CNT_W-1:0] nickel_cnt,
  output logic [CNT_W-1:0] dime_cnt,
  output logic             busy,
  output logic             sync_err
);

  localparam logic [2:0] IDLE = ST_IDLE;
  localparam logic [2:0] LOAD = ST_LOAD;
  localparam logic [2:0] PICK = ST_PICK;
  localparam logic [2:0] CMD  = ST_CMD;
  localparam logic [2:0] GAP  = ST_GAP;
  localparam logic [2:0] DONE = ST_DONE;

  logic [2:0]       state_q, state_d;
  logic             load_q, load_d;
  logic [CNT_W-1:0] nickels_q, nickels_d;
  logic [CNT_W-1:0] dimes_q, dimes_d;
  logic             nickel_out_q, nickel_out_d;
  logic             dime_out_q, dime_out_d;
  logic             two_dime_out_q, two_dime_out_d;
  logic             done_valid_q, done_valid_d;
  logic             done_short_q, done_short_d;
  logic [AMT_W-1:0] done_remain_q, done_remain_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] nickel_cnt_q, nickel_cnt_d;
  logic [CNT_W-1:0] dime_cnt_q, dime_cnt_d;
  logic             sync_err_q, sync_err_d;
  logic             chk_skip_q, chk_skip_d;

  logic             pick_go_s;
  logic [AMT_W-1:0] pick_rem_in_s;
  logic [AMT_W-1:0] pick_rem_nxt_s;
  logic [CNT_W-1:0] pick_nickel_nxt_s;
  logic [CNT_W-1:0] pick_dime_nxt_s;
  cmd_t             pick_cmd_s;
  logic [2:0]       cmd_bits_s;
  logic             mirror_empty_s;

  // In IDLE the selection runs on the incoming amount so the first command
  // can be registered on the acceptance edge; in PICK it runs on remaining.
  assign pick_rem_in_s  = (state_q == IDLE) ? req_amount : remaining_q;
  assign mirror_empty_s = (nickel_cnt_q == {CNT_W{1'b0}}) && (dime_cnt_q == {CNT_W{1'b0}});

  coin_pick #(
    .CNT_W (CNT_W),
    .AMT_W (AMT_W)
  ) u_pick (
    .remaining      (pick_rem_in_s),
    .nickel_cnt     (nickel_cnt_q),
    .dime_cnt       (dime_cnt_q),
    .cmd            (pick_cmd_s),
    .remaining_nxt  (pick_rem_nxt_s),
    .nickel_cnt_nxt (pick_nickel_nxt_s),
    .dime_cnt_nxt   (pick_dime_nxt_s)
  );

  // Next-state, command and mirror update logic.
  always_comb begin
    state_d        = state_q;
    load_d         = 1'b0;
    nickels_d      = {CNT_W{1'b0}};
    dimes_d        = {CNT_W{1'b0}};
    nickel_out_d   = 1'b0;
    dime_out_d     = 1'b0;
    two_dime_out_d = 1'b0;
    done_valid_d   = 1'b0;
    done_short_d   = 1'b0;
    done_remain_d  = {AMT_W{1'b0}};
    remaining_d    = remaining_q;
    nickel_cnt_d   = nickel_cnt_q;
    dime_cnt_d     = dime_cnt_q;
    sync_err_d     = sync_err_q;
    chk_skip_d     = 1'b0;
    pick_go_s      = 1'b0;
    cmd_bits_s     = 3'b000;

    case (state_q)
      IDLE: begin
        // The first IDLE cycle after a load gap is skipped so the datapath's
        // empty flag has settled on the freshly loaded counts.
        if (!chk_skip_q && (empty != mirror_empty_s)) begin
          sync_err_d = 1'b1;
        end else begin
          sync_err_d = sync_err_q;
        end
        if (load_req) begin
          state_d      = LOAD;
          load_d       = 1'b1;
          nickels_d    = load_nickels;
          dimes_d      = load_dimes;
          nickel_cnt_d = load_nickels;
          dime_cnt_d   = load_dimes;
          sync_err_d   = 1'b0;
        end else if (req_valid) begin
          pick_go_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: state_d = GAP;
      GAP: begin
        state_d    = IDLE;
        chk_skip_d = 1'b1;
      end
      CMD:  state_d = PICK;
      PICK: pick_go_s = 1'b1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Issue the selected coin, or finish when nothing more can be paid.
    if (pick_go_s) begin
      if (pick_cmd_s == CMD_NONE) begin
        state_d       = DONE;
        done_valid_d  = 1'b1;
        done_short_d  = (pick_rem_in_s != {AMT_W{1'b0}});
        done_remain_d = pick_rem_in_s;
        remaining_d   = {AMT_W{1'b0}};
      end else begin
        state_d      = CMD;
        cmd_bits_s   = cmd_onehot(pick_cmd_s);
        two_dime_out_d = cmd_bits_s[2];
        dime_out_d     = cmd_bits_s[1];
        nickel_out_d   = cmd_bits_s[0];
        remaining_d  = pick_rem_nxt_s;
        nickel_cnt_d = pick_nickel_nxt_s;
        dime_cnt_d   = pick_dime_nxt_s;
      end
    end else begin
      cmd_bits_s = 3'b000;
    end
  end

  // State, registered outputs and inventory mirror.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      load_q         <= 1'b0;
      nickels_q      <= {CNT_W{1'b0}};
      dimes_q        <= {CNT_W{1'b0}};
      nickel_out_q   <= 1'b0;
      dime_out_q     <= 1'b0;
      two_dime_out_q <= 1'b0;
      done_valid_q   <= 1'b0;
      done_short_q   <= 1'b0;
      done_remain_q  <= {AMT_W{1'b0}};
      remaining_q    <= {AMT_W{1'b0}};
      nickel_cnt_q   <= {CNT_W{1'b0}};
      dime_cnt_q     <= {CNT_W{1'b0}};
      sync_err_q     <= 1'b0;
      chk_skip_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_q         <= load_d;
      nickels_q      <= nickels_d;
      dimes_q        <= dimes_d;
      nickel_out_q   <= nickel_out_d;
      dime_out_q     <= dime_out_d;
      two_dime_out_q <= two_dime_out_d;
      done_valid_q   <= done_valid_d;
      done_short_q   <= done_short_d;
      done_remain_q  <= done_remain_d;
      remaining_q    <= remaining_d;
      nickel_cnt_q   <= nickel_cnt_d;
      dime_cnt_q     <= dime_cnt_d;
      sync_err_q     <= sync_err_d;
      chk_skip_q     <= chk_skip_d;
    end
  end

  // req_ready is gated by rst_n so every output reads 0 while in reset.
  assign req_ready    = rst_n && (state_q == IDLE) && !load_req;
  assign busy         = (state_q != IDLE);
  assign done_valid   = done_valid_q;
  assign done_short   = done_short_q;
  assign done_remain  = done_remain_q;
  assign load         = load_q;
  assign nickels      = nickels_q;
  assign dimes        = dimes_q;
  assign nickel_out   = nickel_out_q;
  assign dime_out     = dime_out_q;
  assign two_dime_out = two_dime_out_q;
  assign nickel_cnt   = nickel_cnt_q;
  assign dime_cnt     = dime_cnt_q;
  assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Testbench for change_dispense_ctrl: a datapath model tracks the real coin
// counts, expected commands and completions are queued as stimulus is driven
// and compared as the DUT produces them.
module tb_change_dispense_ctrl;

  localparam int CNT_W = 8;
  localparam int AMT_W = 8;

  localparam logic [3:0] E_LOAD   = 4'b0001;
  localparam logic [3:0] E_NICKEL = 4'b0010;
  localparam logic [3:0] E_DIME   = 4'b0100;
  localparam logic [3:0] E_TWO    = 4'b1000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_req = 1'b0;
  logic [CNT_W-1:0] load_nickels = 8'd0;
  logic [CNT_W-1:0] load_dimes = 8'd0;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amount = 8'd0;
  logic             req_ready;
  logic             done_valid;
  logic             done_short;
  logic [AMT_W-1:0] done_remain;
  logic             load;
  logic [CNT_W-1:0] nickels;
  logic [CNT_W-1:0] dimes;
  logic             nickel_out;
  logic             dime_out;
  logic             two_dime_out;
  logic             empty;
  logic [CNT_W-1:0] nickel_cnt;
  logic [CNT_W-1:0] dime_cnt;
  logic             busy;
  logic             sync_err;

  int checks = 0;
  int errors = 0;

  logic [3:0]       exp_cmd_q[$];
  logic [AMT_W:0]   exp_done_q[$];
  logic [CNT_W-1:0] dp_n = 8'd0;
  logic [CNT_W-1:0] dp_d = 8'd0;
  logic             force_en = 1'b0;
  logic             force_val = 1'b0;

  assign empty = force_en ? force_val : ((dp_n == 8'd0) && (dp_d == 8'd0));

  always #5 clk = ~clk;

  change_dispense_ctrl #(.CNT_W(CNT_W), .AMT_W(AMT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_req     (load_req),
    .load_nickels (load_nickels),
    .load_dimes   (load_dimes),
    .req_valid    (req_valid),
    .req_amount   (req_amount),
    .req_ready    (req_ready),
    .done_valid   (done_valid),
    .done_short   (done_short),
    .done_remain  (done_remain),
    .load         (load),
    .nickels      (nickels),
    .dimes        (dimes),
    .nickel_out   (nickel_out),
    .dime_out     (dime_out),
    .two_dime_out (two_dime_out),
    .empty        (empty),
    .nickel_cnt   (nickel_cnt),
    .dime_cnt     (dime_cnt),
    .busy         (busy),
    .sync_err     (sync_err)
  );

  function automatic logic [48:0] all_outs();
    return {load, nickels, dimes, nickel_out, dime_out, two_dime_out, done_valid,
            done_short, done_remain, nickel_cnt, dime_cnt, busy, sync_err, req_ready};
  endfunction

  // Scoreboard side: datapath model plus comparison of every command/done.
  task automatic monitor();
    logic [3:0]     prev;
    logic [3:0]     cur;
    logic [3:0]     exp_c;
    logic [AMT_W:0] exp_d;
    prev = 4'b0000;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        dp_n = 8'd0;
        dp_d = 8'd0;
        prev = 4'b0000;
      end else begin
        cur = {two_dime_out, dime_out, nickel_out, load};
        if (cur != 4'b0000) begin
          checks++;
          if (($countones(cur) != 1) || (prev != 4'b0000)) begin
            errors++;
            $display("FAIL cmd_shape: got %b after %b, required one-hot after an idle cycle", cur, prev);
          end
          checks++;
          if (exp_cmd_q.size() == 0) begin
            errors++;
            $display("FAIL cmd_unexpected: got %b, required no command", cur);
          end else begin
            exp_c = exp_cmd_q.pop_front();
            if (cur !== exp_c) begin
              errors++;
              $display("FAIL cmd_order: got %b, required %b", cur, exp_c);
            end
          end
          if (cur[0]) begin
            dp_n = nickels;
            dp_d = dimes;
          end
          if (cur[1] || cur[2] || cur[3]) begin
            checks++;
            if ((cur[1] && dp_n < 8'd1) || (cur[2] && dp_d < 8'd1) || (cur[3] && dp_d < 8'd2)) begin
              errors++;
              $display("FAIL dp_underflow: cmd %b with %0dN/%0dD, required enough coins", cur, dp_n, dp_d);
            end else begin
              if (cur[1]) dp_n = dp_n - 8'd1;
              if (cur[2]) dp_d = dp_d - 8'd1;
              if (cur[3]) dp_d = dp_d - 8'd2;
            end
          end
        end
        if (done_valid) begin
          checks++;
          if (exp_done_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: got short=%b remain=%0d, required no done", done_short, done_remain);
          end else begin
            exp_d = exp_done_q.pop_front();
            if ({done_short, done_remain} !== exp_d) begin
              errors++;
              $display("FAIL done_result: got short=%b remain=%0d, required short=%b remain=%0d",
                       done_short, done_remain, exp_d[AMT_W], exp_d[AMT_W-1:0]);
            end
          end
        end
        prev = cur;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%b, required 0 within 200 cycles", busy);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_valid && n < 200);
    if (!done_valid) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done_valid=%b, required 1 within 200 cycles", done_valid);
    end
  endtask

  task automatic do_load(input logic [CNT_W-1:0] n, input logic [CNT_W-1:0] d);
    wait_idle();
    exp_cmd_q.push_back(E_LOAD);
    load_req = 1'b1;
    load_nickels = n;
    load_dimes = d;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic issue_req(input logic [AMT_W-1:0] amt);
    wait_idle();
    req_valid = 1'b1;
    req_amount = amt;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (all_outs() !== 49'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", all_outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    do_load(8'd3, 8'd2);
    @(negedge clk);
    checks++;
    if ({busy, load, nickels, dimes} !== {1'b1, 1'b1, 8'd3, 8'd2}) begin
      errors++;
      $display("FAIL load_pulse: got busy=%b load=%b %0d/%0d, required 1 1 3/2", busy, load, nickels, dimes);
    end
    @(negedge clk);
    checks++;
    if ({busy, load} !== 2'b10) begin
      errors++;
      $display("FAIL load_gap: got busy=%b load=%b, required 1 0", busy, load);
    end
    @(negedge clk);
    checks++;
    if ({busy, nickel_cnt, dime_cnt, sync_err} !== {1'b0, 8'd3, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL load_mirror: got busy=%b %0dN/%0dD sync=%b, required 0 3N/2D 0", busy, nickel_cnt, dime_cnt, sync_err);
    end
  endtask

  task automatic test_mixed();
    exp_cmd_q.push_back(E_TWO);
    exp_cmd_q.push_back(E_NICKEL);
    exp_cmd_q.push_back(E_NICKEL);
    exp_cmd_q.push_back(E_NICKEL);
    exp_done_q.push_back({1'b0, 8'd0});
    issue_req(8'd7);
    @(negedge clk);
    checks++;
    if (two_dime_out !== 1'b1) begin
      errors++;
      $display("FAIL mixed_first_cmd: got two_dime_out=%b in cycle 1, required 1", two_dime_out);
    end
    wait_done();
    checks++;
    if ({nickel_cnt, dime_cnt, empty, exp_cmd_q.size() == 0} !== {8'd0, 8'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL mixed_final: got %0dN/%0dD empty=%b pending=%0d, required 0N/0D 1 0",
               nickel_cnt, dime_cnt, empty, exp_cmd_q.size());
    end
  endtask

  task automatic test_shortfall();
    do_load(8'd1, 8'd1);
    exp_cmd_q.push_back(E_DIME);
    exp_cmd_q.push_back(E_NICKEL);
    exp_done_q.push_back({1'b1, 8'd2});
    issue_req(8'd5);
    wait_done();
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL short_ready_done: got req_ready=%b during done, required 0", req_ready);
    end
    @(negedge clk);
    checks++;
    if ({req_ready, nickel_cnt, dime_cnt} !== {1'b1, 8'd0, 8'd0}) begin
      errors++;
      $display("FAIL short_after: got ready=%b %0dN/%0dD, required 1 0N/0D", req_ready, nickel_cnt, dime_cnt);
    end
  endtask

  task automatic test_zero_priority();
    int n;
    exp_done_q.push_back({1'b0, 8'd0});
    issue_req(8'd0);
    @(negedge clk);
    checks++;
    if ({done_valid, done_short, load, nickel_out, dime_out, two_dime_out} !== 6'b100000) begin
      errors++;
      $display("FAIL zero_cycle1: got done=%b short=%b cmds=%b%b%b%b, required 1 0 0000",
               done_valid, done_short, load, nickel_out, dime_out, two_dime_out);
    end
    wait_idle();
    exp_cmd_q.push_back(E_LOAD);
    exp_cmd_q.push_back(E_DIME);
    exp_cmd_q.push_back(E_NICKEL);
    exp_done_q.push_back({1'b0, 8'd0});
    load_req = 1'b1;
    load_nickels = 8'd2;
    load_dimes = 8'd1;
    req_valid = 1'b1;
    req_amount = 8'd3;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_ready: got req_ready=%b with load_req, required 0", req_ready);
    end
    @(posedge clk);
    #1 load_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_done();
    @(negedge clk);
    checks++;
    if ({nickel_cnt, dime_cnt, exp_cmd_q.size() == 0} !== {8'd1, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL prio_final: got %0dN/%0dD pending=%0d, required 1N/0D 0", nickel_cnt, dime_cnt, exp_cmd_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    do_load(8'd0, 8'd5);
    exp_cmd_q.push_back(E_TWO);
    exp_cmd_q.push_back(E_TWO);
    issue_req(8'd10);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({all_outs(), exp_cmd_q.size() == 0} !== {49'd0, 1'b1}) begin
      errors++;
      $display("FAIL midreset_outputs: got %h pending=%0d, required 0 0", all_outs(), exp_cmd_q.size());
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midreset_done: got done_valid after reset, required none");
    end
    exp_done_q.push_back({1'b1, 8'd2});
    issue_req(8'd2);
    wait_done();
  endtask

  task automatic test_sync_err();
    wait_idle();
    force_en = 1'b1;
    force_val = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sync_err !== 1'b1) begin
      errors++;
      $display("FAIL sync_set: got sync_err=%b, required 1", sync_err);
    end
    force_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sync_err !== 1'b1) begin
      errors++;
      $display("FAIL sync_sticky: got sync_err=%b, required 1", sync_err);
    end
    do_load(8'd1, 8'd0);
    @(negedge clk);
    checks++;
    if ({load, sync_err} !== 2'b10) begin
      errors++;
      $display("FAIL sync_clear: got load=%b sync_err=%b, required 1 0", load, sync_err);
    end
    wait_idle();
    repeat (2) @(negedge clk);
    checks++;
    if ({sync_err, nickel_cnt, dime_cnt} !== {1'b0, 8'd1, 8'd0}) begin
      errors++;
      $display("FAIL sync_after: got sync_err=%b %0dN/%0dD, required 0 1N/0D", sync_err, nickel_cnt, dime_cnt);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_load();
    test_mixed();
    test_shortfall();
    test_zero_priority();
    test_reset_mid();
    test_sync_err();
    repeat (4) @(negedge clk);
    checks++;
    if ((exp_cmd_q.size() != 0) || (exp_done_q.size() != 0)) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d cmds %0d dones pending, required 0 0",
               exp_cmd_q.size(), exp_done_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
